binary_decoder_seq: RTL
=======================

# binary_decoder_seq

Sequenced 3-to-8 decoder: accepts 3-bit binary codes over a valid/ready handshake, buffers them in a small FIFO, and drives each as a registered one-hot word on an 8-bit bus for a fixed number of cycles. It sits downstream of the 8:3 binary encoder path and turns encoded indices back into one-hot select lines, such as strobes and row/bank enables, with guaranteed pulse width and no dropped codes.

## Interface
- `N`, 3: code width; the output is `2**N` bits wide.
- `HOLD`, 4: cycles each one-hot word is driven. Legal range 1..255.
- `DEPTH`, 4: FIFO entries. Must be a power of two, at least 2.
- `clk`  input  1  rising-edge clock, the only clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  `in_code` is valid.
- `in_ready`  output  1  the block can accept a code.
- `in_code`  input  N  binary code, 0..2**N-1.
- `out_onehot`  output  2**N  registered one-hot word; all zero when not driving.
- `out_valid`  output  1  `out_onehot` is currently driven.
- `busy`  output  1  FIFO non-empty or FSM in DRIVE.
- `level`  output  clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Accept:** a code is accepted on a rising edge where `in_valid & in_ready`. `in_ready = (level != DEPTH)`, purely from registered state.
- **FIFO:** circular buffer with rd/wr pointers of clog2(DEPTH) bits; pointers wrap modulo DEPTH.
  - `level` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
  - Push when full cannot occur, because `in_ready` is low.
- **FSM states:**
  - IDLE: `out_valid=0`, `out_onehot=0`.
    - If FIFO non-empty: pop the head, load `out_onehot = 1 << code` and `cnt = HOLD-1`, go to DRIVE.
  - DRIVE: `out_valid=1`, `out_onehot` is held.
    - If `cnt != 0`: decrement `cnt`.
    - If `cnt == 0` and FIFO non-empty: pop and load the next code back-to-back (no idle gap), with `cnt = HOLD-1`.
    - If `cnt == 0` and FIFO empty: go to IDLE and clear `out_onehot`.
- **Simultaneous push and pop:** allowed in any state, including when `level==DEPTH` at the start of the cycle (pop frees a slot, but `in_ready` was already low, so no push that cycle).
- **Empty FIFO:** a code pushed into an empty FIFO is not passed through; it is popped on the following edge at the earliest.
- **One-hot invariant:** `out_onehot` has exactly one bit set when `out_valid=1` and is zero otherwise. Codes are always in range because `in_code` is exactly N bits.
- **`busy`:** `busy = (level != 0) | (state == DRIVE)`.
- **Reset:** reset is asynchronous at any time, including mid-DRIVE. It forces:
  - state IDLE, `cnt=0`, pointers 0, `level=0`;
  - `out_onehot=0`, `out_valid=0`, `busy=0`, `in_ready=1`.
  
  FIFO contents are discarded. On the first edge after `rst_n` deasserts, the block behaves as from a cold start.

## Timing
- **Latency:** code accepted at edge k with the FSM in IDLE and FIFO empty → `out_valid=1` and the matching `out_onehot` visible after edge k+1. Latency is 2 edges from the presentation edge of the handshake.
- **Pulse width:** each code is driven for exactly HOLD consecutive cycles.
- **Back-to-back codes:** consecutive queued codes produce contiguous pulses with no gap. Throughput is one code per HOLD cycles.
- **HOLD=1:** one cycle per code. With codes streamed at `in_valid=1` every cycle, `in_ready` stays high and `level` does not exceed 1.
- **Registered outputs:** all outputs are registers or pure functions of registers. There is no combinational path from `in_valid` or `in_code` to any output.

## Test plan
- **Reset values:** assert `rst_n=0` for 3 cycles, then release → `out_onehot=8'h00`, `out_valid=0`, `in_ready=1`, `level=0`, `busy=0`.
- **Single code, HOLD=4:** push code 5 → two edges later `out_onehot=8'h20` for exactly 4 cycles, then `8'h00` and `out_valid=0`.
- **Sweep, HOLD=4:** push codes 0..7 back-to-back → `out_onehot` = 01, 02, 04, … 80, each for 4 cycles with no gaps. `in_ready` drops while `level==4` and resumes as pops occur; total of 32 driven cycles, no code lost or reordered.
- **Full FIFO:** hold `in_valid=1` with codes 3,3,3,… while output is busy → `level` saturates at 4, `in_ready=0`, and no push is counted while full. Check with a scoreboard that accepted count equals emitted count.
- **HOLD=1 streaming:** push 8 codes on consecutive cycles → 8 contiguous one-cycle one-hot pulses matching input order; `in_ready` stays 1.
- **Reset mid-operation:** with `level=3` and DRIVE of code 6 active, pulse `rst_n` low asynchronously between edges → outputs clear immediately, with no further pulses. Code 1 pushed afterwards → `8'h02` with 2-edge latency.

Source files
------------

// File: rtl/binary_decoder_seq_if.sv
// Handshake and one-hot output bus of the sequenced 3-to-8 decoder.
// The producer side uses the master modport; the decoder uses the slave modport.
interface binary_decoder_seq_if #(
  parameter int N     = 3,
  parameter int DEPTH = 4
);
  localparam int W  = 1 << N;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_code;
  logic [W-1:0]  out_onehot;
  logic          out_valid;
  logic          busy;
  logic [LW-1:0] level;

  modport master (
    output in_valid, in_code,
    input  in_ready, out_onehot, out_valid, busy, level
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, out_onehot, out_valid, busy, level
  );
endinterface

// File: rtl/binary_decoder_seq.sv
// Sequenced N-to-2**N decoder: queues binary codes in a small FIFO and drives
// each as a registered one-hot word for exactly HOLD cycles, back-to-back.
module binary_decoder_seq #(
  parameter int N     = 3,
  parameter int HOLD  = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  binary_decoder_seq_if.slave bus
);
  localparam int W  = 1 << N;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [7:0]    CNT_RELOAD = 8'(HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [W-1:0]  onehot_q, onehot_d;
  logic [N-1:0]  head_code;
  logic          push, pop, fifo_empty, in_ready;

  assign fifo_empty = (level_q == '0);
  assign in_ready   = (level_q != FULL_LEVEL);
  assign push       = bus.in_valid & in_ready;
  assign head_code  = mem_q[rd_ptr_q];

  // ---------------- FIFO ----------------
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; level/pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_code;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every signal gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop               = 1'b1;
          onehot_d          = '0;
          onehot_d[head_code] = 1'b1;
          cnt_d             = CNT_RELOAD;
          state_d           = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!fifo_empty) begin
          // Reload straight from the head so consecutive pulses abut.
          pop                 = 1'b1;
          onehot_d            = '0;
          onehot_d[head_code] = 1'b1;
          cnt_d               = CNT_RELOAD;
        end else begin
          onehot_d = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        onehot_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.out_valid = (state_q == DRIVE);
    bus.busy      = !fifo_empty || (state_q == DRIVE);
  end

  assign bus.out_onehot = onehot_q;
  assign bus.in_ready   = in_ready;
  assign bus.level      = level_q;
endmodule
